moore_pattern_gen: RTL and testbench

Serial pattern transmitter: the stimulus-side counterpart of the team's Moore sequence detectors. On a start request it latches a PAT_W-bit pattern and shifts it out MSB-first on a single serial line, once or a programmed number of times, with optional idle gaps between repetitions. Its serial output drives a detector's `in` input directly in system-level benches and self-check loops. Its state is exposed on `pst`/`nst` in the same way the detectors expose theirs.

---
 rtl/moore_pkg.sv | 30 +++
 rtl/patgen_shreg.sv | 43 ++++
 rtl/moore_pattern_gen.sv | 207 ++++++++++++++++++++
 tb/tb_moore_pattern_gen.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/moore_pkg.sv
// ============================================================================
// Module  : moore_pkg
// Purpose : Shared definitions for the Moore-style sequence blocks (pattern
//           generator and detectors): state width and state encodings.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package moore_pkg;

  // State vector width shared by every Moore block in the family.
  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_SHIFT = 3'd1;
  localparam logic [ST_W-1:0] ST_GAP   = 3'd2;
  localparam logic [ST_W-1:0] ST_DONE  = 3'd3;

  // Encodings 4..7 are unused; the FSMs recover from them to IDLE.
  typedef enum logic [ST_W-1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    GAP   = ST_GAP,
    DONE  = ST_DONE
  } state_t;

endpackage

`default_nettype wire

// File: rtl/patgen_shreg.sv
// ============================================================================
// Module  : patgen_shreg
// Purpose : PAT_W-bit loadable left-shift register feeding the serial output
//           of the pattern generator. Load has priority over shift; zeros
//           are shifted in at the LSB.
// Ports   : clk   - rising-edge clock
//           rst   - asynchronous active-high reset (clears the register)
//           load  - load din on the next edge
//           shift - shift left by one on the next edge (when not loading)
//           din   - parallel load data
//           msb   - current most significant bit
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module patgen_shreg #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] din,
  output logic             msb
);

  logic [PAT_W-1:0] shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= {shreg[PAT_W-2:0], 1'b0};
    end
  end

  assign msb = shreg[PAT_W-1];

endmodule

`default_nettype wire

// File: rtl/moore_pattern_gen.sv
// ============================================================================
// Module  : moore_pattern_gen
// Purpose : Serial pattern transmitter. On an accepted start it latches a
//           PAT_W-bit pattern and shifts it out MSB-first, max(reps,1) times,
//           optionally separated by 'gap' idle cycles.
// Config  : PATGEN_GAP_EN - when defined, the GAP state and the gap input are
//           active; when undefined, repetitions are always back-to-back, the
//           gap input is ignored and encoding 2 is illegal.
// Ports   : clk     - rising-edge clock
//           rst     - asynchronous active-high reset
//           start   - transfer request, sampled only in IDLE
//           pattern - bits to send (MSB first), latched on accepted start
//           reps    - number of passes (0 behaves as 1), latched on start
//           gap     - idle cycles between passes, latched on start
//           q       - serial data, 0 whenever valid=0
//           valid   - q carries a pattern bit
//           busy    - high in SHIFT, GAP and DONE
//           done    - one-cycle pulse after the final bit
//           pst     - present state
//           nst     - next state (combinational)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module moore_pattern_gen
  import moore_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             q,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [ST_W-1:0]  pst,
  output logic [ST_W-1:0]  nst
);

  localparam logic [PAT_W-1:0] BIT_LAST = PAT_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);

  state_t           pst_r;
  state_t           nst_s;
  logic [PAT_W-1:0] pat_copy;
  logic [PAT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic [PAT_W-1:0] load_data;
  logic             load;
  logic             shift;
  logic             pass_end;
  logic             more_reps;
  logic             shreg_msb;
  logic             valid_r;
  logic             busy_r;
  logic             done_r;

`ifdef PATGEN_GAP_EN
  logic [GAP_W-1:0] gap_reg;
  logic [GAP_W-1:0] gap_cnt;
`else
  // The gap port stays on the interface but has no function in this build.
  logic unused_gap;
  assign unused_gap = ^gap;
`endif

  // --------------------------------------------------------------------------
  // Next-state and datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    nst_s     = IDLE;
    load      = 1'b0;
    shift     = 1'b0;
    pass_end  = 1'b0;
    load_data = pat_copy;
    // rep_cnt still holds the current pass; >1 means another pass follows.
    more_reps = (rep_cnt > REP_ONE);
    case (pst_r)
      IDLE: begin
        if (start) begin
          nst_s     = SHIFT;
          load      = 1'b1;
          load_data = pattern;
        end
      end
      SHIFT: begin
        if (bit_cnt == BIT_LAST) begin
          pass_end = 1'b1;
          if (more_reps) begin
`ifdef PATGEN_GAP_EN
            if (gap_reg != '0) begin
              nst_s = GAP;
            end else begin
              nst_s = SHIFT;
              load  = 1'b1;
            end
`else
            nst_s = SHIFT;
            load  = 1'b1;
`endif
          end else begin
            nst_s = DONE;
          end
        end else begin
          nst_s = SHIFT;
          shift = 1'b1;
        end
      end
`ifdef PATGEN_GAP_EN
      GAP: begin
        // gap_cnt counts cycles already spent in GAP; the last one reloads.
        if (gap_cnt == (gap_reg - GAP_W'(1))) begin
          nst_s = SHIFT;
          load  = 1'b1;
        end else begin
          nst_s = GAP;
        end
      end
`endif
      DONE: begin
        nst_s = IDLE;
      end
      default: begin
        nst_s = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State, counters and registered Moore outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pst_r    <= IDLE;
      pat_copy <= '0;
      bit_cnt  <= '0;
      rep_cnt  <= '0;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef PATGEN_GAP_EN
      gap_reg  <= '0;
      gap_cnt  <= '0;
`endif
    end else begin
      pst_r <= nst_s;

      if (pst_r == IDLE && start) begin
        pat_copy <= pattern;
        rep_cnt  <= (reps == '0) ? REP_ONE : reps;
`ifdef PATGEN_GAP_EN
        gap_reg  <= gap;
`endif
      end else if (pass_end) begin
        rep_cnt <= rep_cnt - REP_ONE;
      end

      if (load) begin
        bit_cnt <= '0;
      end else if (shift) begin
        bit_cnt <= bit_cnt + PAT_W'(1);
      end

`ifdef PATGEN_GAP_EN
      if (pst_r == GAP) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end else begin
        gap_cnt <= '0;
      end
`endif

      // Outputs are registered from the state being entered, so they line
      // up with pst and never depend combinationally on start.
      valid_r <= (nst_s == SHIFT);
      busy_r  <= (nst_s == SHIFT) || (nst_s == GAP) || (nst_s == DONE);
      done_r  <= (nst_s == DONE);
    end
  end

  patgen_shreg #(
    .PAT_W (PAT_W)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (load_data),
    .msb   (shreg_msb)
  );

  // q is gated by the registered valid so it is 0 outside SHIFT.
  assign q     = valid_r & shreg_msb;
  assign valid = valid_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign pst   = pst_r;
  assign nst   = nst_s;

endmodule

`default_nettype wire

// File: tb/tb_moore_pattern_gen.sv
// ============================================================================
// Module  : tb_moore_pattern_gen
// Purpose : Self-checking bench for moore_pattern_gen. A table of transfers
//           is applied; a reference model pushes the expected per-cycle
//           output stream into a queue that is popped and compared as the
//           DUT runs. Hand-written sequences cover reset behaviour.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_moore_pattern_gen;
  import moore_pkg::*;

  localparam int PAT_W = 4;
  localparam int CNT_W = 4;
  localparam int GAP_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] reps;
  logic [GAP_W-1:0] gap;
  logic             q;
  logic             valid;
  logic             busy;
  logic             done;
  logic [2:0]       pst;
  logic [2:0]       nst;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       q;
    logic       valid;
    logic       busy;
    logic       done;
    logic [2:0] pst;
  } obs_t;

  typedef struct {
    string            name;
    logic [PAT_W-1:0] pat;
    logic [CNT_W-1:0] reps;
    logic [GAP_W-1:0] gap;
    bit               disturb;
  } vec_t;

  obs_t exp_q[$];

  moore_pattern_gen #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W),
    .GAP_W (GAP_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .reps    (reps),
    .gap     (gap),
    .q       (q),
    .valid   (valid),
    .busy    (busy),
    .done    (done),
    .pst     (pst),
    .nst     (nst)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t sample();
    obs_t o;
    o = {q, valid, busy, done, pst};
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual q/valid/busy/done/pst=%b/%b/%b/%b/%0d required %b/%b/%b/%b/%0d",
               name, act.q, act.valid, act.busy, act.done, act.pst,
               exp.q, exp.valid, exp.busy, exp.done, exp.pst);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int eff_gap(input logic [GAP_W-1:0] g);
`ifdef PATGEN_GAP_EN
    return int'(g);
`else
    return 0;
`endif
  endfunction

  // Reference model: expected output stream for the cycles following the
  // edge that accepts start, ending with one IDLE cycle.
  task automatic push_expected(input logic [PAT_W-1:0] pat,
                               input logic [CNT_W-1:0] r_in,
                               input logic [GAP_W-1:0] g_in,
                               output int exp_busy);
    int   r;
    int   g;
    obs_t e;
    r = (r_in == 0) ? 1 : int'(r_in);
    g = eff_gap(g_in);
    for (int p = 0; p < r; p++) begin
      for (int i = PAT_W - 1; i >= 0; i--) begin
        e = {pat[i], 1'b1, 1'b1, 1'b0, 3'd1};
        exp_q.push_back(e);
      end
      if (p < r - 1) begin
        for (int j = 0; j < g; j++) begin
          e = {1'b0, 1'b0, 1'b1, 1'b0, 3'd2};
          exp_q.push_back(e);
        end
      end
    end
    e = {1'b0, 1'b0, 1'b1, 1'b1, 3'd3};
    exp_q.push_back(e);
    e = {1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    exp_q.push_back(e);
    exp_busy = r * PAT_W + (r - 1) * g + 1;
  endtask

  task automatic run_txn(input string name, input logic [PAT_W-1:0] pat,
                         input logic [CNT_W-1:0] r, input logic [GAP_W-1:0] g,
                         input bit disturb);
    int   exp_busy;
    int   busy_cnt;
    int   idx;
    obs_t e;
    @(negedge clk);
    pattern = pat;
    reps    = r;
    gap     = g;
    start   = 1'b1;
    #1;
    check_val({name, " nst_on_start"}, int'(nst), 1);
    push_expected(pat, r, g, exp_busy);
    @(negedge clk);
    start    = 1'b0;
    busy_cnt = 0;
    idx      = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_obs($sformatf("%s cyc%0d", name, idx), sample(), e);
      if (busy) busy_cnt++;
      if (disturb) begin
        // Mid-SHIFT: new start and new inputs must be ignored; a start
        // raised during DONE must also be ignored.
        if (idx == 1) begin
          start   = 1'b1;
          pattern = ~pat;
          reps    = 4'd5;
          gap     = 3'd7;
        end else if (e.done) begin
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
      idx++;
      @(negedge clk);
    end
    start = 1'b0;
    check_val({name, " busy_cycles"}, busy_cnt, exp_busy);
  endtask

  vec_t vecs[6];

  initial begin
    obs_t zero;
    zero = '0;

    vecs[0] = '{"single_1001",   4'b1001, 4'd1, 3'd0, 1'b0};
    vecs[1] = '{"gap_1011_x3",   4'b1011, 4'd3, 3'd2, 1'b0};
    vecs[2] = '{"b2b_1001_x2",   4'b1001, 4'd2, 3'd0, 1'b0};
    vecs[3] = '{"busy_start",    4'b1100, 4'd1, 3'd0, 1'b1};
    vecs[4] = '{"reps_zero",     4'b0110, 4'd0, 3'd3, 1'b0};
    vecs[5] = '{"gap1_0111_x2",  4'b0111, 4'd2, 3'd1, 1'b0};

    rst     = 1'b0;
    start   = 1'b0;
    pattern = '0;
    reps    = '0;
    gap     = '0;
    #1 rst  = 1'b1;
    #1;
    check_obs("reset_outputs", sample(), zero);
    check_val("reset_nst", int'(nst), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_obs("idle_after_reset", sample(), zero);

    for (int v = 0; v < 6; v++) begin
      run_txn(vecs[v].name, vecs[v].pat, vecs[v].reps, vecs[v].gap, vecs[v].disturb);
    end

    // Asynchronous reset during the second bit of a pass.
    @(negedge clk);
    pattern = 4'b1001;
    reps    = 4'd1;
    gap     = 3'd0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_obs("pre_reset_bit3", sample(), obs_t'({1'b1, 1'b1, 1'b1, 1'b0, 3'd1}));
    @(posedge clk);
    #2;
    check_obs("pre_reset_bit2", sample(), obs_t'({1'b0, 1'b1, 1'b1, 1'b0, 3'd1}));
    rst = 1'b1;
    #1;
    check_obs("async_reset_now", sample(), zero);
    check_val("async_reset_nst", int'(nst), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check_obs($sformatf("post_reset_quiet%0d", c), sample(), zero);
      @(negedge clk);
    end
    run_txn("after_reset", 4'b1001, 4'd1, 3'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
